// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: receive-only PS/2 front end. Synchronizes and glitch-filters the
// raw ps2_clk/ps2_data pad lines, deserializes 11-bit device-to-host frames,
// checks start/parity/stop and presents each valid byte with a one-cycle strobe.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   ps2_clk      raw PS/2 clock pad (asynchronous)
//   ps2_data     raw PS/2 data pad (asynchronous)
//   dout         last valid received byte (held until the next valid frame)
//   rx_done_tick one-cycle strobe, dout just updated
//   frame_err    one-cycle strobe on start/parity/stop error or timeout
//   busy         high while a frame is in progress
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned FCW = 4;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned BCW = 4;
  localparam int unsigned SRW = 10;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic           clk_meta, clk_s, data_meta, data_s;
  logic           clk_f, fall_tick;
  logic [FCW-1:0] fcnt;

  state_t         state, state_n;
  logic [BCW-1:0] bit_cnt, bit_cnt_n;
  logic [TW-1:0]  tmo_cnt, tmo_cnt_n;
  logic [SRW-1:0] shreg, shreg_n;
  logic [7:0]     dout_n;
  logic           done_n, err_n, busy_n;

  // 2-flop synchronizers, clock glitch filter and registered falling-edge pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
      clk_f     <= 1'b1;
      fcnt      <= '0;
      fall_tick <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk;
      clk_s     <= clk_meta;
      data_meta <= ps2_data;
      data_s    <= data_meta;
      fall_tick <= 1'b0;
      if (clk_s == clk_f) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
        // FILTER_LEN consecutive differing samples: accept the new level
        clk_f     <= clk_s;
        fcnt      <= '0;
        fall_tick <= ~clk_s;
      end else begin
        fcnt <= fcnt + FCW'(1);
      end
    end
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tmo_cnt      <= '0;
      shreg        <= '0;
      dout         <= 8'h00;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      tmo_cnt      <= tmo_cnt_n;
      shreg        <= shreg_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= err_n;
      busy         <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    tmo_cnt_n = tmo_cnt;
    shreg_n   = shreg;
    dout_n    = dout;
    done_n    = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        // an edge with data high is not a start bit and is silently ignored
        if (fall_tick && !data_s) begin
          bit_cnt_n = '0;
          tmo_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        // a falling edge wins over a coincident timeout
        if (fall_tick) begin
          shreg_n   = {data_s, shreg[SRW-1:1]};
          bit_cnt_n = bit_cnt + BCW'(1);
          tmo_cnt_n = '0;
          if (bit_cnt == BCW'(9)) state_n = CHECK;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + TW'(1);
        end
      end
      CHECK: begin
        // shreg = {stop, parity, data[7:0]}; odd parity over data+parity
        state_n = IDLE;
        if ((^shreg[8:0]) && shreg[9]) begin
          dout_n = shreg[7:0];
          done_n = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed testbench for ps2_rx_frame: valid, back-to-back, parity error,
// clock glitch, timeout and mid-frame reset scenarios.
module tb_ps2_rx_frame;

  localparam int unsigned FL = 8;
  localparam int unsigned TO = 1000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick, frame_err, busy;

  int checks = 0;
  int errors = 0;

  // strobe monitor
  int         done_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0;
  logic       prev_done = 1'b0, prev_err = 1'b0;
  logic [7:0] dq[$];

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  // 10 MHz system clock: a 60 us PS/2 bit period is 600 cycles
  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      dq.push_back(dout);
    end
    if (frame_err) err_cnt++;
    if (rx_done_tick && frame_err) both_cnt++;
    if ((rx_done_tick && prev_done) || (frame_err && prev_err)) long_cnt++;
    prev_done = rx_done_tick;
    prev_err  = frame_err;
  end

  initial begin
    #9ms;
    $display("FAIL watchdog: simulation did not complete (time %0t, limit 9ms)", $time);
    $fatal(1, "watchdog expired");
  end

  // one bit: data set while clock high, 30 us low, clock back high
  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (150) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (300) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (150) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(1'b1);
    repeat (50) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (dout !== 8'h00)       begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rx_done_tick); end
    checks++; if (frame_err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_valid_frame();
    logic [7:0] d = 8'h1C;
    int d0 = done_cnt, e0 = err_cnt, lat = 0;
    send_bit(1'b0);
    send_bit(d[0]);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL valid_busy_mid: got %b want 1", busy); end
    for (int i = 1; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);  // parity of 1C (three ones) is 0
    // stop bit with latency measurement from the raw falling edge
    @(negedge clk) ps2_data = 1'b1;
    repeat (150) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (rx_done_tick && lat == 0) lat = i;
    end
    ps2_clk = 1'b1;
    repeat (150) @(negedge clk);
    checks++; if (lat < FL + 3 || lat > FL + 5) begin errors++; $display("FAIL valid_latency: got %0d cycles want %0d..%0d", lat, FL + 3, FL + 5); end
    checks++; if (dout !== 8'h1C) begin errors++; $display("FAIL valid_dout: got %h want 1c", dout); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL valid_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0)  begin errors++; $display("FAIL valid_err_count: got %0d want 0", err_cnt - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL valid_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, e0 = err_cnt;
    int n0 = dq.size();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'((8'hF0 >> i) & 8'h01));
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h1C, 1'b0);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0)  begin errors++; $display("FAIL b2b_err_count: got %0d want 0", err_cnt - e0); end
    if (dq.size() >= n0 + 2) begin
      checks++; if (dq[n0] !== 8'hF0)     begin errors++; $display("FAIL b2b_first: got %h want f0", dq[n0]); end
      checks++; if (dq[n0 + 1] !== 8'h1C) begin errors++; $display("FAIL b2b_second: got %h want 1c", dq[n0 + 1]); end
    end else begin
      checks++; errors++; $display("FAIL b2b_bytes: got %0d bytes want 2", dq.size() - n0);
    end
  endtask

  task automatic test_parity_error();
    int d0 = done_cnt, e0 = err_cnt;
    send_frame(8'h1C, 1'b1);
    checks++; if (err_cnt - e0 !== 1)  begin errors++; $display("FAIL parity_err_count: got %0d want 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL parity_done_count: got %0d want 0", done_cnt - d0); end
    checks++; if (dout !== 8'h1C) begin errors++; $display("FAIL parity_dout_kept: got %h want 1c", dout); end
  endtask

  task automatic test_glitch();
    int d0 = done_cnt, e0 = err_cnt;
    logic busy_seen = 1'b0;
    @(negedge clk) ps2_data = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL glitch_busy: got 1 want 0"); end
    checks++; if (done_cnt - d0 + err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_strobes: got %0d want 0", done_cnt - d0 + err_cnt - e0); end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt, lat = 0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'((8'h29 >> i) & 8'h01));
    // fifth data bit is the last edge, measure from its raw fall
    @(negedge clk) ps2_data = 1'b0;
    repeat (150) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= int'(TO) + 200; i++) begin
      @(negedge clk);
      if (i == 300) ps2_clk = 1'b1;
      if (frame_err && lat == 0) lat = i;
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    checks++; if (lat < int'(TO + FL) || lat > int'(TO + FL) + 6) begin errors++; $display("FAIL timeout_latency: got %0d cycles want %0d..%0d", lat, TO + FL, TO + FL + 6); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err_count: got %0d want 1", err_cnt - e0); end
    send_frame(8'h29, 1'b0);
    checks++; if (dout !== 8'h29) begin errors++; $display("FAIL timeout_next_dout: got %h want 29", dout); end
  endtask

  task automatic test_reset_midframe();
    int d0 = done_cnt, e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'((8'h5A >> i) & 8'h01));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dout !== 8'h00)        begin errors++; $display("FAIL rstmid_dout: got %h want 00", dout); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (rx_done_tick !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: got %b%b want 00", rx_done_tick, frame_err); end
    rst = 1'b1;
    repeat (50) @(negedge clk);
    send_frame(8'h5A, 1'b0);
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL rstmid_dout_after: got %h want 5a", dout); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0)  begin errors++; $display("FAIL rstmid_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_strobe_shape();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", both_cnt); end
    checks++; if (long_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d long pulses want 0", long_cnt); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_back_to_back();
    test_parity_error();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_strobe_shape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
